// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU-to-SRAM arbiter.
// Owner encoding, response tag layout and default parameters.
package cpu_mem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STRB_W         = 4;
  localparam int unsigned STREAK_W       = 4;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_LATENCY    = 1;
  localparam int unsigned DEF_MAX_STREAK = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the SRAM.
// slave = arbiter side, master = CPU core plus memory side.
interface cpu_sram_arbiter_if #(
  parameter int unsigned ADDR_W = cpu_mem_pkg::DEF_ADDR_W
);
  import cpu_mem_pkg::*;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_en;
  logic [STRB_W-1:0] mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/arb_tag_pipe.sv
// LATENCY-deep {valid, owner} shift register tracking accesses in flight.
// Stages shift every cycle; the last stage marks the returning response.
module arb_tag_pipe
  import cpu_mem_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic busy
);

  tag_t stage_q [LATENCY];
  logic busy_q;
  logic busy_d;

  // busy_d is the OR of the valid bits the stages will hold after this edge
  always_comb begin
    busy_d = tag_in.valid;
    for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
      busy_d = busy_d | stage_q[i].valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      busy_q <= 1'b0;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      busy_q <= busy_d;
    end
  end

  assign tag_out = stage_q[LATENCY-1];
  assign busy    = busy_q;

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one fixed-latency SRAM between the CPU fetch and load/store ports.
// Data has priority; a streak counter forces a fetch after MAX_STREAK data grants.
module cpu_sram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
  input logic               clk,
  input logic               resetn,
  cpu_sram_arbiter_if.slave bus
);

  logic                gnt_i;
  logic                gnt_d;
  logic                streak_ok;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic [ADDR_W-1:0]   addr_sel;
  tag_t                tag_in;
  tag_t                tag_out;
  logic                busy;

  assign streak_ok = streak_q < STREAK_W'(MAX_STREAK);

  // Grants are gated by resetn so nothing is accepted while reset is held
  always_comb begin
    gnt_d = resetn & bus.data_req & (~bus.inst_req | streak_ok);
    gnt_i = resetn & bus.inst_req & ~gnt_d;
  end

  always_comb begin
    streak_d = streak_q;
    if (!bus.inst_req || gnt_i) begin
      streak_d = '0;
    end else if (gnt_d && streak_ok) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  always_comb begin
    addr_sel = gnt_d ? bus.data_addr : bus.inst_addr;
    tag_in   = '{valid: gnt_i | gnt_d, owner: gnt_d};
  end

  assign bus.inst_addr_ok = gnt_i;
  assign bus.data_addr_ok = gnt_d;
  assign bus.mem_en       = gnt_i | gnt_d;
  assign bus.mem_addr     = addr_sel;
  assign bus.mem_wen      = (gnt_d && bus.data_wr) ? bus.data_wstrb : STRB_W'(0);
  assign bus.mem_wdata    = bus.data_wdata;

  arb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .busy    (busy)
  );

  // Responses are routed by the owner recorded at grant time
  assign bus.inst_data_ok = tag_out.valid && (tag_out.owner == OWNER_INST);
  assign bus.data_data_ok = tag_out.valid && (tag_out.owner == OWNER_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
  assign bus.busy         = busy;

endmodule
